mac_unit: RTL and testbench

MAC_UNIT -- requirements
Module: mac_unit

---
 rtl/mac_unit_pkg.sv | 19 +
 rtl/mac_unit.sv | 110 +++++++++++
 tb/tb_mac_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mac_unit_pkg.sv
// Shared opcode definitions for the SAP-1 multiply-accumulate unit.
package mac_unit_pkg;

    // Width of the opcode field sampled by the MAC unit.
    localparam int OPCODE_WIDTH = 4;

    // Operation codes. Codes 8-15 are unassigned and behave as NOP.
    typedef enum logic [OPCODE_WIDTH-1:0] {
        NOP       = 4'd0,
        MAC_RESET = 4'd1,
        MAC_REGA  = 4'd2,
        MAC_REGB  = 4'd3,
        MAC_MULT  = 4'd4,
        MAC_ACC   = 4'd5,
        MAC_MSW   = 4'd6,
        MAC_LSW   = 4'd7
    } mac_op_e;

endpackage : mac_unit_pkg

// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate unit: two operand registers, a full-width
// product register, a double-width accumulator with a sticky carry flag, and
// a registered output that exposes either half of the accumulator.
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [3:0]            opcode,
    output logic                  acc_overflow,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int AW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] reg_a;
    logic [DATA_WIDTH-1:0] reg_b;
    logic [AW-1:0]         product;
    logic [AW-1:0]         acc;

    // Decoded single-cycle operation strobes
    logic do_clear;
    logic do_load_a;
    logic do_load_b;
    logic do_mult;
    logic do_acc;
    logic do_msw;
    logic do_lsw;

    logic [AW:0]   acc_sum;
    logic [AW-1:0] mult_result;

    // Unsigned add that returns the carry-out in the top bit.
    function automatic logic [AW:0] add_with_carry(input logic [AW-1:0] x,
                                                   input logic [AW-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Zero-extended unsigned multiply; the full product always fits in AW bits.
    function automatic logic [AW-1:0] mul_full(input logic [DATA_WIDTH-1:0] x,
                                               input logic [DATA_WIDTH-1:0] y);
        return {{DATA_WIDTH{1'b0}}, x} * {{DATA_WIDTH{1'b0}}, y};
    endfunction

    assign acc_sum     = add_with_carry(acc, product);
    assign mult_result = mul_full(reg_a, reg_b);

    // Decode the opcode into one-hot strobes; unassigned codes fall to NOP.
    always_comb begin
        do_clear  = 1'b0;
        do_load_a = 1'b0;
        do_load_b = 1'b0;
        do_mult   = 1'b0;
        do_acc    = 1'b0;
        do_msw    = 1'b0;
        do_lsw    = 1'b0;
        case (opcode)
            MAC_RESET: do_clear  = 1'b1;
            MAC_REGA:  do_load_a = 1'b1;
            MAC_REGB:  do_load_b = 1'b1;
            MAC_MULT:  do_mult   = 1'b1;
            MAC_ACC:   do_acc    = 1'b1;
            MAC_MSW:   do_msw    = 1'b1;
            MAC_LSW:   do_lsw    = 1'b1;
            default:   ;
        endcase
    end

    // All datapath state updates; every register holds unless its strobe fires.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            reg_a        <= '0;
            reg_b        <= '0;
            product      <= '0;
            acc          <= '0;
            acc_overflow <= 1'b0;
            data_out     <= '0;
        end else begin
            if (do_clear) begin
                product      <= '0;
                acc          <= '0;
                acc_overflow <= 1'b0;
            end
            if (do_load_a) begin
                reg_a <= data_in;
            end
            if (do_load_b) begin
                reg_b <= data_in;
            end
            if (do_mult) begin
                product <= mult_result;
            end
            if (do_acc) begin
                // Carry-out is OR-ed in so the flag stays set once raised.
                acc          <= acc_sum[AW-1:0];
                acc_overflow <= acc_overflow | acc_sum[AW];
            end
            if (do_msw) begin
                data_out <= acc[AW-1:DATA_WIDTH];
            end
            if (do_lsw) begin
                data_out <= acc[DATA_WIDTH-1:0];
            end
        end
    end

endmodule : mac_unit

// File: tb/tb_mac_unit.sv
// Directed self-checking bench for mac_unit with hand-computed expectations.
module tb_mac_unit;
    import mac_unit_pkg::*;

    logic       clk;
    logic       a_reset_n;
    logic [7:0] data_in;
    logic [3:0] opcode;
    logic       acc_overflow;
    logic [7:0] data_out;

    int vectors;
    int miscompares;

    mac_unit #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .a_reset_n    (a_reset_n),
        .data_in      (data_in),
        .opcode       (opcode),
        .acc_overflow (acc_overflow),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one opcode for one rising edge, then settle just past the edge.
    task automatic step(input logic [3:0] op, input logic [7:0] d);
        @(negedge clk);
        opcode  = op;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic load_mult_acc(input logic [7:0] a, input logic [7:0] b);
        step(MAC_REGA, a);
        step(MAC_REGB, b);
        step(MAC_MULT, 8'h00);
        step(MAC_ACC, 8'h00);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        opcode      = NOP;
        data_in     = 8'h00;
        a_reset_n   = 1'b1;
        #1 a_reset_n = 1'b0;
        #2;
        chk8("reset_data_out", data_out, 8'h00);
        chk1("reset_ovf", acc_overflow, 1'b0);
        @(negedge clk);
        a_reset_n = 1'b1;

        // 390 + 190 + 51 = 631 = 0x0277
        step(MAC_RESET, 8'h00);
        load_mult_acc(8'h0F, 8'h1A);
        load_mult_acc(8'h26, 8'h05);
        load_mult_acc(8'h03, 8'h11);
        step(MAC_MSW, 8'h00);
        chk8("sum631_msw", data_out, 8'h02);
        step(MAC_LSW, 8'h00);
        chk8("sum631_lsw", data_out, 8'h77);
        chk1("sum631_ovf", acc_overflow, 1'b0);

        // 0xFD02 then + 0xF90C wraps to 0xF60E with carry
        step(MAC_RESET, 8'h00);
        load_mult_acc(8'hFF, 8'hFE);
        chk1("fd02_ovf", acc_overflow, 1'b0);
        step(MAC_MSW, 8'h00);
        chk8("fd02_msw", data_out, 8'hFD);
        load_mult_acc(8'hFD, 8'hFC);
        chk1("wrap_ovf", acc_overflow, 1'b1);
        step(MAC_MSW, 8'h00);
        chk8("wrap_msw", data_out, 8'hF6);
        step(MAC_LSW, 8'h00);
        chk8("wrap_lsw", data_out, 8'h0E);

        // Non-overflowing ACC keeps the sticky flag
        load_mult_acc(8'h01, 8'h01);
        chk1("sticky_ovf", acc_overflow, 1'b1);
        chk8("hold_over_acc", data_out, 8'h0E);
        step(MAC_LSW, 8'h00);
        chk8("f60f_lsw", data_out, 8'h0F);
        step(MAC_MSW, 8'h00);
        chk8("f60f_msw", data_out, 8'hF6);

        // NOP and unassigned codes leave everything alone
        step(4'd0, 8'hAA);
        for (int op = 8; op < 16; op++) begin
            step(4'(op), 8'h55);
        end
        chk8("nop_data_out", data_out, 8'hF6);
        chk1("nop_ovf", acc_overflow, 1'b1);
        step(MAC_LSW, 8'h00);
        chk8("nop_acc_lsw", data_out, 8'h0F);
        step(MAC_MSW, 8'h00);
        chk8("nop_acc_msw", data_out, 8'hF6);

        // MAC_RESET clears flag and accumulator but not data_out
        step(MAC_RESET, 8'h00);
        chk1("macreset_ovf", acc_overflow, 1'b0);
        chk8("macreset_hold", data_out, 8'hF6);
        step(MAC_LSW, 8'h00);
        chk8("macreset_lsw", data_out, 8'h00);

        // ACC held two cycles adds 0x0100 twice
        load_mult_acc(8'h10, 8'h10);
        step(MAC_ACC, 8'h00);
        step(MAC_LSW, 8'h00);
        chk8("acc2_lsw", data_out, 8'h00);
        step(MAC_MSW, 8'h00);
        chk8("acc2_msw", data_out, 8'h02);

        // Async reset between edges with loaded state and flag set
        load_mult_acc(8'hFF, 8'hFF);
        load_mult_acc(8'hFF, 8'hFF);
        step(MAC_MSW, 8'h00);
        chk1("pre_areset_ovf", acc_overflow, 1'b1);
        chk8("pre_areset_msw", data_out, 8'hFE);
        opcode = NOP;
        #2 a_reset_n = 1'b0;
        #1;
        chk8("areset_data_out", data_out, 8'h00);
        chk1("areset_ovf", acc_overflow, 1'b0);
        @(negedge clk);
        a_reset_n = 1'b1;
        step(MAC_ACC, 8'h00);
        step(MAC_MSW, 8'h00);
        chk8("post_areset_msw", data_out, 8'h00);
        step(MAC_MULT, 8'h00);
        step(MAC_ACC, 8'h00);
        step(MAC_LSW, 8'h00);
        chk8("post_areset_lsw", data_out, 8'h00);
        chk1("post_areset_ovf", acc_overflow, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule : tb_mac_unit
